// File: rtl/io_digital_tube_if.sv
// Store-side bus into the 7-segment tube window plus the board-facing
// segment/enable pins.
interface io_digital_tube_if;
  logic        io_write;
  logic        digital_ctrl;
  logic [3:0]  addr;
  logic [31:0] write_data;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  modport master (
    output io_write, digital_ctrl, addr, write_data,
    input  seg_en, seg_out
  );

  modport slave (
    input  io_write, digital_ctrl, addr, write_data,
    output seg_en, seg_out
  );
endinterface

// File: rtl/io_digital_tube.sv
// 8-digit multiplexed hex display: captures CPU stores into display, blank
// and decimal-point registers and scans one digit per SCAN_DIV clocks.
module io_digital_tube #(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  io_digital_tube_if.slave  bus
);

  typedef enum logic [1:0] {
    REG_DISP  = 2'b00,
    REG_BLANK = 2'b01,
    REG_DP    = 2'b10,
    REG_NONE  = 2'b11
  } reg_sel_e;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [31:0]      disp_data_q,  disp_data_d;
  logic [7:0]       blank_mask_q, blank_mask_d;
  logic [7:0]       dp_mask_q,    dp_mask_d;
  logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
  logic [2:0]       digit_idx_q,  digit_idx_d;
  logic [7:0]       seg_en_q,     seg_en_d;
  logic [7:0]       seg_out_q,    seg_out_d;

  logic     wr_en;
  reg_sel_e reg_sel;
  logic     unused_addr_lsbs;

  // Word-aligned register window: the byte offset within a word is don't-care.
  assign unused_addr_lsbs = ^bus.addr[1:0];
  assign wr_en            = bus.io_write & bus.digital_ctrl;
  assign reg_sel          = reg_sel_e'(bus.addr[3:2]);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    disp_data_d  = disp_data_q;
    blank_mask_d = blank_mask_q;
    dp_mask_d    = dp_mask_q;
    if (wr_en) begin
      case (reg_sel)
        REG_DISP:  disp_data_d  = bus.write_data;
        REG_BLANK: blank_mask_d = bus.write_data[7:0];
        REG_DP:    dp_mask_d    = bus.write_data[7:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    div_cnt_d   = div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d   = '0;
      digit_idx_d = digit_idx_q + 3'd1;
    end
  end

  // Driven from the current registers, so a write or index step lands on the
  // pins exactly one edge later, and a coincident write+step never shows stale data.
  always_comb begin
    seg_en_d  = 8'hFF;
    seg_out_d = 8'hFF;
    if (!blank_mask_q[digit_idx_q]) begin
      seg_en_d  = ~(8'b1 << digit_idx_q);
      seg_out_d = ~{dp_mask_q[digit_idx_q], hex7(disp_data_q[4*digit_idx_q +: 4])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data_q  <= '0;
      blank_mask_q <= '0;
      dp_mask_q    <= '0;
      div_cnt_q    <= '0;
      digit_idx_q  <= '0;
      seg_en_q     <= 8'hFF;
      seg_out_q    <= 8'hFF;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      disp_data_q  <= disp_data_d;
      blank_mask_q <= blank_mask_d;
      dp_mask_q    <= dp_mask_d;
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      seg_en_q     <= seg_en_d;
      seg_out_q    <= seg_out_d;
    end
  end

  assign bus.seg_en  = seg_en_q;
  assign bus.seg_out = seg_out_q;

endmodule

// File: tb/tb_io_digital_tube.sv
// Directed bench for io_digital_tube with a 4-cycle scan slot: table of
// writes and per-digit expectations plus reset and write-on-step sequences.
module tb_io_digital_tube;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  io_digital_tube_if bus ();

  io_digital_tube #(.SCAN_DIV(SCAN_DIV), .DIV_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic        cs;
    logic [3:0]  addr;
    logic [31:0] data;
    int          digit;
    logic [7:0]  en;
    logic [7:0]  seg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic wr, logic cs, logic [3:0] a,
                              logic [31:0] d, int dig, logic [7:0] en, logic [7:0] seg);
    vec_t v;
    v.name = n; v.wr = wr; v.cs = cs; v.addr = a; v.data = d;
    v.digit = dig; v.en = en; v.seg = seg;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Output slot for the sample taken after edge cyc (edges counted from reset release).
  function automatic int out_digit();
    return ((cyc - 1) / SCAN_DIV) % 8;
  endfunction

  task automatic goto_digit(input int d);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(out_digit() == d && (cyc - 1) % SCAN_DIV == 0) && n < 64);
    if (n >= 64) begin
      failures++;
      $display("FAIL goto_digit%0d: timed out after %0d cycles", d, n);
    end
  endtask

  task automatic bus_write(input logic wr, input logic cs, input logic [3:0] a,
                           input logic [31:0] d);
    bus.io_write = wr; bus.digital_ctrl = cs; bus.addr = a; bus.write_data = d;
    step();
    bus.io_write = 1'b0; bus.digital_ctrl = 1'b0; bus.addr = '0; bus.write_data = '0;
  endtask

  initial begin
    // seg_out values are ~{dp, hex7}: e.g. F -> ~71 = 8E, F with dp -> 0E.
    vecs.push_back(mk("disp_d0",    1, 1, 4'h0, 32'h89AB_CDEF, 0, 8'hFE, 8'h8E));
    vecs.push_back(mk("disp_d1",    0, 0, 4'h0, 32'h0,         1, 8'hFD, 8'h86));
    vecs.push_back(mk("disp_d2",    0, 0, 4'h0, 32'h0,         2, 8'hFB, 8'hA1));
    vecs.push_back(mk("disp_d3",    0, 0, 4'h0, 32'h0,         3, 8'hF7, 8'hC6));
    vecs.push_back(mk("disp_d4",    0, 0, 4'h0, 32'h0,         4, 8'hEF, 8'h83));
    vecs.push_back(mk("disp_d5",    0, 0, 4'h0, 32'h0,         5, 8'hDF, 8'h88));
    vecs.push_back(mk("disp_d6",    0, 0, 4'h0, 32'h0,         6, 8'hBF, 8'h90));
    vecs.push_back(mk("disp_d7",    0, 0, 4'h0, 32'h0,         7, 8'h7F, 8'h80));
    vecs.push_back(mk("wrap_d0",    0, 0, 4'h0, 32'h0,         0, 8'hFE, 8'h8E));
    vecs.push_back(mk("blank_d1",   1, 1, 4'h4, 32'h0000_0002, 1, 8'hFF, 8'hFF));
    vecs.push_back(mk("blank_d2",   0, 0, 4'h0, 32'h0,         2, 8'hFB, 8'hA1));
    vecs.push_back(mk("blank_d0",   0, 0, 4'h0, 32'h0,         0, 8'hFE, 8'h8E));
    vecs.push_back(mk("dp_d0",      1, 1, 4'h8, 32'h0000_0001, 0, 8'hFE, 8'h0E));
    vecs.push_back(mk("dp_zero_d0", 1, 1, 4'h0, 32'h0000_0000, 0, 8'hFE, 8'h40));
    vecs.push_back(mk("unblank_d1", 1, 1, 4'h4, 32'h0000_0000, 1, 8'hFD, 8'hC0));
    vecs.push_back(mk("gate_cs0",   1, 0, 4'h0, 32'hFFFF_FFFF, 0, 8'hFE, 8'h40));
    vecs.push_back(mk("gate_wr0",   0, 1, 4'h4, 32'hFFFF_FFFF, 1, 8'hFD, 8'hC0));
    vecs.push_back(mk("gate_a12",   1, 1, 4'hC, 32'hFFFF_FFFF, 0, 8'hFE, 8'h40));
    vecs.push_back(mk("gate_a12_1", 0, 0, 4'h0, 32'h0,         1, 8'hFD, 8'hC0));
    vecs.push_back(mk("addr_lsb_7", 1, 1, 4'h9, 32'h0000_0080, 7, 8'h7F, 8'h40));
    vecs.push_back(mk("addr_lsb_0", 0, 0, 4'h0, 32'h0,         0, 8'hFE, 8'hC0));

    rst_n = 1'b0;
    bus.io_write = 1'b0; bus.digital_ctrl = 1'b0; bus.addr = '0; bus.write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_en", bus.seg_en, 8'hFF);
    check("reset_seg", bus.seg_out, 8'hFF);
    rst_n = 1'b1;
    cyc = 0;
    step(); step();
    check("release_en", bus.seg_en, 8'hFE);
    check("release_seg", bus.seg_out, 8'hC0);

    foreach (vecs[i]) begin
      if (vecs[i].wr || vecs[i].cs)
        bus_write(vecs[i].wr, vecs[i].cs, vecs[i].addr, vecs[i].data);
      goto_digit(vecs[i].digit);
      check({vecs[i].name, "_en"},  bus.seg_en,  vecs[i].en);
      check({vecs[i].name, "_seg"}, bus.seg_out, vecs[i].seg);
      repeat (SCAN_DIV - 1) step();
      check({vecs[i].name, "_en_end"},  bus.seg_en,  vecs[i].en);
      check({vecs[i].name, "_seg_end"}, bus.seg_out, vecs[i].seg);
    end

    // Write on the edge where the index steps 0 -> 1; digit 1 must show it at once.
    goto_digit(0);
    step(); step();
    bus_write(1'b1, 1'b1, 4'h0, 32'h0000_0050);
    check("coinc_old_en", bus.seg_en, 8'hFE);
    check("coinc_old_seg", bus.seg_out, 8'hC0);
    step();
    check("coinc_new_en", bus.seg_en, 8'hFD);
    check("coinc_new_seg", bus.seg_out, 8'h92);

    // Asynchronous reset in the middle of a slot.
    goto_digit(3);
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_en", bus.seg_en, 8'hFF);
    check("midrst_seg", bus.seg_out, 8'hFF);
    @(posedge clk);
    #1;
    check("midrst_hold_en", bus.seg_en, 8'hFF);
    rst_n = 1'b1;
    cyc = 0;
    step(); step();
    check("midrst_rel_en", bus.seg_en, 8'hFE);
    check("midrst_rel_seg", bus.seg_out, 8'hC0);
    step(); step();
    check("midrst_slot_end_en", bus.seg_en, 8'hFE);
    step();
    check("midrst_d1_en", bus.seg_en, 8'hFD);
    check("midrst_d1_seg", bus.seg_out, 8'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
